// File: rtl/vmatmul_ctrl.sv
// ---------------------------------------------------------------------------
// vmatmul_ctrl
//   Sequencing controller for the vector matrix-multiply datapath. Computes
//   C = A x B over unsigned 32-bit words by walking the i/j/k loop nest. It
//   drives a one-cycle-latency vector memory and accumulates the k-products
//   internally, writing each C element exactly once.
//
//   Optional build macro: VMATMUL_CTRL_ACC_SAT_EN
//     When defined, the accumulator saturates at 0xFFFFFFFF and uses full
//     64-bit products. When undefined, accumulation wraps mod 2^32.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   start                 request a new multiply (sampled only in IDLE)
//   base_a/b/c            byte base addresses of A, B, C (row-major)
//   num_i/j/k             matrix dimensions
//   busy, done            run-in-progress flag, one-cycle completion pulse
//   mem_re, addr_a/b      read strobe and A/B word addresses
//   rd_a, rd_b            A/B read data, valid the cycle after mem_re
//   we_c, addr_c, wd_c    C write strobe, address and data
//   cur_i/j/k             current loop indices
// ---------------------------------------------------------------------------
module vmatmul_ctrl #(
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [IDX_W-1:0]  num_i,
  input  logic [IDX_W-1:0]  num_j,
  input  logic [IDX_W-1:0]  num_k,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       rd_a,
  input  logic [31:0]       rd_b,
  output logic              we_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic [31:0]       wd_c,
  output logic [IDX_W-1:0]  cur_i,
  output logic [IDX_W-1:0]  cur_j,
  output logic [IDX_W-1:0]  cur_k
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  i_q, j_q, k_q;
  logic [IDX_W-1:0]  cfg_ni, cfg_nj, cfg_nk;
  logic [ADDR_W-1:0] cfg_ba, cfg_bb, cfg_bc;
  logic [31:0]       acc;

  logic last_i, last_j, last_k, any_zero;
  logic [ADDR_W-1:0] off_a, off_b, off_c;

  // One accumulate step: add the product of the returned A/B words.
  function automatic logic [31:0] mac_step(input logic [31:0] acc_in,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
`ifdef VMATMUL_CTRL_ACC_SAT_EN
    logic [63:0] prod;
    logic [64:0] sum;
    prod = 64'(a) * 64'(b);
    sum  = 65'(acc_in) + 65'(prod);
    // Once saturated, acc stays at all-ones because every later sum is >= it.
    return (sum > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
`else
    logic [31:0] prod;
    prod = a * b;
    return acc_in + prod;
`endif
  endfunction

  assign last_i   = (i_q == cfg_ni - IDX_W'(1));
  assign last_j   = (j_q == cfg_nj - IDX_W'(1));
  assign last_k   = (k_q == cfg_nk - IDX_W'(1));
  assign any_zero = (num_i == '0) || (num_j == '0) || (num_k == '0);

  // Word offsets computed at address width; wrap is intentional.
  assign off_a = ADDR_W'(i_q) * ADDR_W'(cfg_nk) + ADDR_W'(k_q);
  assign off_b = ADDR_W'(k_q) * ADDR_W'(cfg_nj) + ADDR_W'(j_q);
  assign off_c = ADDR_W'(i_q) * ADDR_W'(cfg_nj) + ADDR_W'(j_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs; start only affects the next state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    we_c      = 1'b0;
    addr_a    = '0;
    addr_b    = '0;
    addr_c    = '0;
    wd_c      = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = any_zero ? S_DONE : S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        mem_re    = 1'b1;
        addr_a    = cfg_ba + (off_a << 2);
        addr_b    = cfg_bb + (off_b << 2);
        state_nxt = S_MAC;
      end
      S_MAC: begin
        busy      = 1'b1;
        state_nxt = last_k ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        busy      = 1'b1;
        we_c      = 1'b1;
        addr_c    = cfg_bc + (off_c << 2);
        wd_c      = acc;
        state_nxt = (last_i && last_j) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration snapshot taken when a start is accepted.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cfg_ba <= base_a;
      cfg_bb <= base_b;
      cfg_bc <= base_c;
      cfg_ni <= num_i;
      cfg_nj <= num_j;
      cfg_nk <= num_k;
    end
  end

  // Loop indices and accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      acc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            acc <= '0;
          end
        end
        S_MAC: begin
          acc <= mac_step(acc, rd_a, rd_b);
          if (!last_k) k_q <= k_q + IDX_W'(1);
        end
        S_WRITE: begin
          acc <= '0;
          k_q <= '0;
          if (last_j) begin
            j_q <= '0;
            i_q <= last_i ? '0 : i_q + IDX_W'(1);
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cur_i = i_q;
  assign cur_j = j_q;
  assign cur_k = k_q;

endmodule

// File: tb/tb_vmatmul_ctrl.sv
module tb_vmatmul_ctrl;
  localparam int IDX_W  = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_a = '0, base_b = '0, base_c = '0;
  logic [IDX_W-1:0]  num_i = '0, num_j = '0, num_k = '0;
  logic              busy, done, mem_re, we_c;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [31:0]       rd_a = '0, rd_b = '0, wd_c;
  logic [IDX_W-1:0]  cur_i, cur_j, cur_k;

  vmatmul_ctrl #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .num_i(num_i), .num_j(num_j), .num_k(num_k),
    .busy(busy), .done(done), .mem_re(mem_re),
    .addr_a(addr_a), .addr_b(addr_b), .rd_a(rd_a), .rd_b(rd_b),
    .we_c(we_c), .addr_c(addr_c), .wd_c(wd_c),
    .cur_i(cur_i), .cur_j(cur_j), .cur_k(cur_k)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Word memory with one-cycle read latency.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_re) begin
      rd_a <= mem.exists(addr_a) ? mem[addr_a] : 32'hDEAD_BEEF;
      rd_b <= mem.exists(addr_b) ? mem[addr_b] : 32'hDEAD_BEEF;
    end
  end

  // Observed activity, sampled on the falling edge.
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  int busy_cnt, done_cnt, re_cnt, conflict_cnt;
  always @(negedge clk) begin
    if (we_c) begin
      wr_addr_q.push_back(addr_c);
      wr_data_q.push_back(wd_c);
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_re) re_cnt++;
    if (mem_re && we_c) conflict_cnt++;
  end

  // Reference matrices and expected writes.
  logic [31:0] a_vals[], b_vals[];
  logic [31:0] exp_addr[$], exp_data[$];

  task automatic place(input int ni, input int nj, input int nk,
                       input logic [31:0] ba, input logic [31:0] bb);
    mem.delete();
    for (int x = 0; x < ni * nk; x++) mem[ba + 32'(4 * x)] = a_vals[x];
    for (int x = 0; x < nk * nj; x++) mem[bb + 32'(4 * x)] = b_vals[x];
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j]; wrap mod 2^32, or clamp to all-ones.
  task automatic model(input int ni, input int nj, input int nk, input logic [31:0] bc);
    logic [63:0] s;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < ni; i++)
      for (int j = 0; j < nj; j++) begin
        s = '0;
        for (int k = 0; k < nk; k++) begin
          s = s + 64'(a_vals[i*nk+k]) * 64'(b_vals[k*nj+j]);
`ifdef VMATMUL_CTRL_ACC_SAT_EN
          if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
`endif
        end
        exp_addr.push_back(bc + 32'(4 * (i * nj + j)));
        exp_data.push_back(s[31:0]);
      end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    busy_cnt = 0; done_cnt = 0; re_cnt = 0; conflict_cnt = 0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic launch(input int ni, input int nj, input int nk,
                        input logic [31:0] ba, input logic [31:0] bb,
                        input logic [31:0] bc, output bit timed_out);
    @(negedge clk);
    clear_mon();
    base_a = ba; base_b = bb; base_c = bc;
    num_i = IDX_W'(ni); num_j = IDX_W'(nj); num_k = IDX_W'(nk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(timed_out);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, mem_re, we_c} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0000", {busy, done, mem_re, we_c});
    end
    n_assert++;
    if ({addr_a, addr_b, addr_c, wd_c} !== 128'b0) begin
      n_fail++; $display("FAIL reset_buses got %h want 0", {addr_a, addr_b, addr_c, wd_c});
    end
    n_assert++;
    if ({cur_i, cur_j, cur_k} !== 48'b0) begin
      n_fail++; $display("FAIL reset_idx got %h want 0", {cur_i, cur_j, cur_k});
    end
    reset = 1'b1;
  endtask

  task automatic test_example();
    bit to;
    a_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vals = '{32'd5, 32'd6, 32'd7, 32'd8};
    place(2, 2, 2, 32'h000, 32'h100);
    launch(2, 2, 2, 32'h000, 32'h100, 32'h200, to);
    n_assert++;
    if (to) begin n_fail++; $display("FAIL example_timeout got no done want done"); end
    n_assert++;
    if (wr_addr_q.size() != 4) begin
      n_fail++; $display("FAIL example_nwr got %0d want 4", wr_addr_q.size());
    end else begin
      n_assert++;
      if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1],
           wr_addr_q[2], wr_data_q[2], wr_addr_q[3], wr_data_q[3]} !==
          {32'h200, 32'd19, 32'h204, 32'd22, 32'h208, 32'd43, 32'h20C, 32'd50}) begin
        n_fail++; $display("FAIL example_writes got %h/%0d %h/%0d %h/%0d %h/%0d want 200/19 204/22 208/43 20c/50",
          wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1],
          wr_addr_q[2], wr_data_q[2], wr_addr_q[3], wr_data_q[3]);
      end
    end
    n_assert++;
    if (busy_cnt != 20) begin n_fail++; $display("FAIL example_busy got %0d want 20", busy_cnt); end
    n_assert++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL example_done got %0d want 1", done_cnt); end
    n_assert++;
    if (conflict_cnt != 0) begin n_fail++; $display("FAIL example_excl got %0d want 0", conflict_cnt); end
  endtask

  task automatic test_zero_dim();
    @(negedge clk);
    clear_mon();
    num_i = 3; num_j = 3; num_k = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_assert++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL zero_done_pulse got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b want 0", done); end
    repeat (3) @(negedge clk);
    n_assert++;
    if (re_cnt != 0 || wr_addr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_traffic got re=%0d wr=%0d want 0/0", re_cnt, wr_addr_q.size());
    end
    n_assert++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_single();
    bit to;
    a_vals = '{32'd7};
    b_vals = '{32'd6};
    place(1, 1, 1, 32'h4000, 32'h5000);
    launch(1, 1, 1, 32'h4000, 32'h5000, 32'h6000, to);
    n_assert++;
    if (to || wr_addr_q.size() != 1) begin
      n_fail++; $display("FAIL single_nwr got %0d timeout=%b want 1", wr_addr_q.size(), to);
    end else begin
      n_assert++;
      if ({wr_addr_q[0], wr_data_q[0]} !== {32'h6000, 32'd42}) begin
        n_fail++; $display("FAIL single_write got %0d@%h want 42@6000", wr_data_q[0], wr_addr_q[0]);
      end
    end
    n_assert++;
    if (busy_cnt != 3 || re_cnt != 1) begin
      n_fail++; $display("FAIL single_timing got busy=%0d re=%0d want 3/1", busy_cnt, re_cnt);
    end
  endtask

  task automatic test_random();
    bit to;
    int ni, nj, nk, bad;
    logic [31:0] ba, bb, bc;
    for (int it = 0; it < 8; it++) begin
      ni = $urandom_range(1, 3); nj = $urandom_range(1, 3); nk = $urandom_range(1, 4);
      a_vals = new[ni * nk];
      b_vals = new[nk * nj];
      foreach (a_vals[x]) a_vals[x] = it[0] ? $urandom : $urandom_range(0, 1000);
      foreach (b_vals[x]) b_vals[x] = it[0] ? $urandom : $urandom_range(0, 1000);
      ba = 32'h0001_0000 + ($urandom_range(0, 255) << 4);
      bb = 32'h0002_0000 + ($urandom_range(0, 255) << 4);
      bc = 32'h0003_0000 + ($urandom_range(0, 255) << 4);
      place(ni, nj, nk, ba, bb);
      model(ni, nj, nk, bc);
      launch(ni, nj, nk, ba, bb, bc, to);
      n_assert++;
      if (to || wr_addr_q.size() != exp_addr.size()) begin
        n_fail++; $display("FAIL rand%0d_nwr got %0d timeout=%b want %0d", it, wr_addr_q.size(), to, exp_addr.size());
      end else begin
        bad = 0;
        foreach (exp_addr[x])
          if (wr_addr_q[x] !== exp_addr[x] || wr_data_q[x] !== exp_data[x]) begin
            if (bad == 0) $display("FAIL rand%0d_write%0d got %h@%h want %h@%h", it, x,
                                   wr_data_q[x], wr_addr_q[x], exp_data[x], exp_addr[x]);
            bad++;
          end
        n_assert++;
        if (bad != 0) n_fail++;
      end
      n_assert++;
      if (busy_cnt != ni * nj * (2 * nk + 1) || re_cnt != ni * nj * nk) begin
        n_fail++; $display("FAIL rand%0d_timing got busy=%0d re=%0d want %0d/%0d", it, busy_cnt, re_cnt,
                           ni * nj * (2 * nk + 1), ni * nj * nk);
      end
      n_assert++;
      if (done_cnt != 1 || conflict_cnt != 0) begin
        n_fail++; $display("FAIL rand%0d_done got done=%0d excl=%0d want 1/0", it, done_cnt, conflict_cnt);
      end
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    int bad;
    a_vals = new[4]; b_vals = new[4];
    foreach (a_vals[x]) a_vals[x] = $urandom_range(0, 99);
    foreach (b_vals[x]) b_vals[x] = $urandom_range(0, 99);
    place(2, 2, 2, 32'h1000, 32'h2000);
    model(2, 2, 2, 32'h3000);
    @(negedge clk);
    clear_mon();
    base_a = 32'h1000; base_b = 32'h2000; base_c = 32'h3000;
    num_i = 2; num_j = 2; num_k = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    base_c = 32'h9000; num_i = 1; num_k = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    n_assert++;
    if (to || wr_addr_q.size() != 4) begin
      n_fail++; $display("FAIL restart_nwr got %0d timeout=%b want 4", wr_addr_q.size(), to);
    end else begin
      bad = 0;
      foreach (exp_addr[x])
        if (wr_addr_q[x] !== exp_addr[x] || wr_data_q[x] !== exp_data[x]) bad++;
      n_assert++;
      if (bad != 0) begin
        n_fail++; $display("FAIL restart_writes got %0d bad first=%h@%h want %h@%h", bad,
                           wr_data_q[0], wr_addr_q[0], exp_data[0], exp_addr[0]);
      end
    end
    n_assert++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    int bad;
    a_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vals = '{32'd5, 32'd6, 32'd7, 32'd8};
    place(2, 2, 2, 32'h000, 32'h100);
    @(negedge clk);
    clear_mon();
    base_a = 32'h000; base_b = 32'h100; base_c = 32'h200;
    num_i = 2; num_j = 2; num_k = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (we_c) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_write got none want a write"); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if ({busy, done, mem_re, we_c, addr_a, addr_b, addr_c, wd_c, cur_i, cur_j, cur_k} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got busy=%b done=%b re=%b we=%b addr_c=%h wd=%h i=%0d j=%0d k=%0d want all 0",
                         busy, done, mem_re, we_c, addr_c, wd_c, cur_i, cur_j, cur_k);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_assert++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_nodone got done=%0d busy=%b want 0/0", done_cnt, busy);
    end
    model(2, 2, 2, 32'h200);
    launch(2, 2, 2, 32'h000, 32'h100, 32'h200, to);
    n_assert++;
    if (to || wr_addr_q.size() != 4) begin
      n_fail++; $display("FAIL rstmid_rerun_nwr got %0d timeout=%b want 4", wr_addr_q.size(), to);
    end else begin
      bad = 0;
      foreach (exp_addr[x])
        if (wr_addr_q[x] !== exp_addr[x] || wr_data_q[x] !== exp_data[x]) bad++;
      n_assert++;
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_rerun_writes got %0d bad want 0", bad); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [31:0] want;
`ifdef VMATMUL_CTRL_ACC_SAT_EN
    want = 32'hFFFF_FFFF;
`else
    want = 32'h0000_0000;
`endif
    a_vals = '{32'hFFFF_FFFF, 32'd2};
    b_vals = '{32'd2, 32'd1};
    place(1, 1, 2, 32'h7000, 32'h7100);
    launch(1, 1, 2, 32'h7000, 32'h7100, 32'h7200, to);
    n_assert++;
    if (to || wr_addr_q.size() != 1) begin
      n_fail++; $display("FAIL wrap_nwr got %0d timeout=%b want 1", wr_addr_q.size(), to);
    end else begin
      n_assert++;
      if ({wr_addr_q[0], wr_data_q[0]} !== {32'h7200, want}) begin
        n_fail++; $display("FAIL wrap_value got %h@%h want %h@7200", wr_data_q[0], wr_addr_q[0], want);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_example();
    test_zero_dim();
    test_single();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
